// File: rtl/se_axil_pkg.sv
`default_nettype none
// ============================================================================
// se_axil_pkg : shared constants for the AXI4-Lite register bank
// Rev 1.0 - initial release
// ============================================================================
package se_axil_pkg;

   localparam int NUM_REGS = 4;
   localparam int IDX_W    = 2;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   localparam logic [IDX_W-1:0] REG0_IDX = 2'd0;
   localparam logic [IDX_W-1:0] REG1_IDX = 2'd1;
   localparam logic [IDX_W-1:0] REG2_IDX = 2'd2;
   localparam logic [IDX_W-1:0] REG3_IDX = 2'd3;

   function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REGS-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/se_axil_regbank.sv
`default_nettype none
// ============================================================================
// se_axil_regbank : four 32-bit AXI4-Lite registers exported to the crypto core
// Optional byte-lane write enables with `define SE_AXIL_WSTRB_EN
// Rev 1.0 - initial release
// ============================================================================
module se_axil_regbank
   import se_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
   output logic [NUM_REGS-1:0]             wr_pulse_o
);

   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

   logic                          r_rst_done;
   logic                          r_aw_full;
   logic [IDX_W-1:0]              r_aw_idx;
   logic                          r_w_full;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
   logic [STRB_W-1:0]             r_w_strb;
   logic                          r_bvalid;
   logic                          r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];

   logic                          w_aw_hs;
   logic                          w_w_hs;
   logic                          w_ar_hs;
   logic                          w_commit;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data;
   logic                          w_unused;

   // Readies stay low until the first clock edge after reset release
   assign s00_axi_awready = r_rst_done & ~r_aw_full;
   assign s00_axi_wready  = r_rst_done & ~r_w_full;
   assign s00_axi_arready = r_rst_done & ~r_rvalid;

   assign w_aw_hs  = s00_axi_awvalid & s00_axi_awready;
   assign w_w_hs   = s00_axi_wvalid  & s00_axi_wready;
   assign w_ar_hs  = s00_axi_arvalid & s00_axi_arready;
   assign w_commit = r_aw_full & r_w_full & ~r_bvalid;

   assign s00_axi_bvalid = r_bvalid;
   assign s00_axi_bresp  = RESP_OKAY;
   assign s00_axi_rvalid = r_rvalid;
   assign s00_axi_rdata  = r_rdata;
   assign s00_axi_rresp  = RESP_OKAY;
   assign wr_pulse_o     = w_commit ? idx_onehot(r_aw_idx) : '0;

   assign reg0_o = r_regs[REG0_IDX];
   assign reg1_o = r_regs[REG1_IDX];
   assign reg2_o = r_regs[REG2_IDX];
   assign reg3_o = r_regs[REG3_IDX];

   assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0], r_w_strb};

`ifdef SE_AXIL_WSTRB_EN
   always_comb begin
      w_wr_data = r_regs[r_aw_idx];
      for (int b = 0; b < STRB_W; b++) begin
         if (r_w_strb[b]) begin
            w_wr_data[8*b +: 8] = r_w_data[8*b +: 8];
         end
      end
   end
`else
   assign w_wr_data = r_w_data;
`endif

   // Write holding slots and response; handshake and commit never coincide
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         r_rst_done <= 1'b0;
         r_aw_full  <= 1'b0;
         r_aw_idx   <= '0;
         r_w_full   <= 1'b0;
         r_w_data   <= '0;
         r_w_strb   <= '0;
         r_bvalid   <= 1'b0;
      end else begin
         r_rst_done <= 1'b1;
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= s00_axi_awaddr[IDX_W+1:2];
         end else if (w_commit) begin
            r_aw_full <= 1'b0;
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= s00_axi_wdata;
            r_w_strb <= s00_axi_wstrb;
         end else if (w_commit) begin
            r_w_full <= 1'b0;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
         end else if (r_bvalid && s00_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Read captures the register before any same-edge commit lands
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= r_regs[s00_axi_araddr[IDX_W+1:2]];
      end else if (r_rvalid && s00_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
         if (!s00_axi_aresetn) begin
            r_regs[gi] <= '0;
         end else if (w_commit && (r_aw_idx == IDX_W'(gi))) begin
            r_regs[gi] <= w_wr_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_se_axil_regbank.sv
`default_nettype none
// ============================================================================
// tb_se_axil_regbank : directed scoreboard bench for se_axil_regbank
// Rev 1.0 - initial release
// ============================================================================
module tb_se_axil_regbank;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [3:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] reg0, reg1, reg2, reg3;
   logic [3:0]  wr_pulse;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] model [4];
   logic [31:0] exp_q [$];

   se_axil_regbank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .s00_axi_aclk(clk),       .s00_axi_aresetn(aresetn),
      .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
      .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
      .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
      .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),
      .s00_axi_bready(bready),
      .s00_axi_araddr(araddr),  .s00_axi_arprot(arprot),
      .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),
      .s00_axi_rvalid(rvalid),  .s00_axi_rready(rready),
      .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3),
      .wr_pulse_o(wr_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish before 400us");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] res;
      res = data;
`ifdef SE_AXIL_WSTRB_EN
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
      end
`else
      if (strb == 4'hF) res = data;
      res = res | (old & 32'h0);
`endif
      return res;
   endfunction

   task automatic check_regs(input string tag);
      check({tag, "_reg0"}, reg0, model[0]);
      check({tag, "_reg1"}, reg1, model[1]);
      check({tag, "_reg2"}, reg2, model[2]);
      check({tag, "_reg3"}, reg3, model[3]);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_readies"}, 32'({awready, wready, arready}), 32'd0);
      check({tag, "_valids"},  32'({bvalid, rvalid}), 32'd0);
      check({tag, "_resps"},   32'({bresp, rresp}), 32'd0);
      check({tag, "_rdata"},   rdata, 32'd0);
      check({tag, "_pulse"},   32'(wr_pulse), 32'd0);
      check({tag, "_regs"},    reg0 | reg1 | reg2 | reg3, 32'd0);
   endtask

   task automatic b_handshake(input string tag);
      int cyc = 0;
      while (!bvalid && cyc < 20) begin tick(); cyc++; end
      check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
      check({tag, "_bresp"}, 32'(bresp), 32'd0);
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int cyc = 0;
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      logic [1:0] idx;
      idx = addr[3:2];
      awaddr = addr; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      while (!(aw_done && w_done) && cyc < 20) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick(); cyc++;
         if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
         if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_accept", 32'({aw_done, w_done}), 32'd3);
      check("wr_pulse", 32'(wr_pulse), 32'd1 << idx);
      model[idx] = merge(model[idx], data, strb);
      tick();
      check("b_latency", 32'(bvalid), 32'd1);
      b_handshake("wr");
      check("wr_pulse_clr", 32'(wr_pulse), 32'd0);
   endtask

   task automatic collect_r(input string tag);
      int cyc = 0;
      logic [31:0] exp;
      while (!rvalid && cyc < 20) begin tick(); cyc++; end
      check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
      check({tag, "_rdata"}, rdata, exp);
      check({tag, "_rresp"}, 32'(rresp), 32'd0);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
   endtask

   task automatic do_read(input logic [3:0] addr, input string tag);
      int cyc = 0;
      araddr = addr; arvalid = 1'b1;
      while (!arready && cyc < 20) begin tick(); cyc++; end
      check({tag, "_arready"}, 32'(arready), 32'd1);
      exp_q.push_back(model[addr[3:2]]);
      tick();
      arvalid = 1'b0;
      check({tag, "_r_latency"}, 32'(rvalid), 32'd1);
      collect_r(tag);
   endtask

   initial begin
      aresetn = 1'b0;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;

      repeat (2) tick();
      check_all_zero("reset");
      @(negedge clk) aresetn = 1'b1;
      tick();

      // Four sequential writes then read-back
      do_write(4'h0, 32'h1, 4'hF);
      do_write(4'h4, 32'h2, 4'hF);
      do_write(4'h8, 32'h3, 4'hF);
      do_write(4'hC, 32'h4, 4'hF);
      check_regs("seq");
      check("seq_reg3_const", reg3, 32'h4);
      do_read(4'h0, "rd0");
      do_read(4'h4, "rd1");
      do_read(4'h8, "rd2");
      do_read(4'hC, "rd3");

      // W three cycles ahead of AW
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      check("wfirst_wready", 32'(wready), 32'd1);
      tick();
      wvalid = 1'b0;
      check("wfirst_wfull", 32'(wready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("wfirst_no_commit", 32'({wr_pulse, bvalid}), 32'd0);
         check("wfirst_reg2_old", reg2, model[2]);
         tick();
      end
      awaddr = 4'h8; awvalid = 1'b1;
      check("wfirst_awready", 32'(awready), 32'd1);
      tick();
      awvalid = 1'b0;
      check("wfirst_pulse", 32'(wr_pulse), 32'b0100);
      model[2] = 32'hDEADBEEF;
      tick();
      check("wfirst_b_latency", 32'(bvalid), 32'd1);
      check("wfirst_reg2", reg2, 32'hDEADBEEF);
      b_handshake("wfirst");

      // Held B response with a second pair queued behind it
      awaddr = 4'h0; awvalid = 1'b1; wdata = 32'hA5A50000; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check("hold_pulse0", 32'(wr_pulse), 32'b0001);
      model[0] = 32'hA5A50000;
      tick();
      awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h77; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("hold_b", 32'({bvalid, bresp}), 32'b100);
         check("hold_no_commit", 32'(wr_pulse), 32'd0);
         check("hold_slots_full", 32'({awready, wready}), 32'd0);
         check("hold_reg3_old", reg3, model[3]);
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("hold_bvalid_drop", 32'(bvalid), 32'd0);
      check("hold_pulse3", 32'(wr_pulse), 32'b1000);
      model[3] = 32'h77;
      tick();
      check("hold_reg3_new", reg3, 32'h77);
      b_handshake("hold2");

      // Read and commit to the same register on the same edge
      wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      awaddr = 4'h4; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("coll_pulse", 32'(wr_pulse), 32'b0010);
      araddr = 4'h4; arvalid = 1'b1;
      check("coll_arready", 32'(arready), 32'd1);
      exp_q.push_back(model[1]);
      model[1] = 32'h55;
      tick();
      arvalid = 1'b0;
      check("coll_old_const", rdata, 32'h2);
      collect_r("coll");
      b_handshake("coll");
      do_read(4'h4, "coll_new");

      // Byte strobes, including an all-zero strobe
      do_write(4'h4, 32'h11223344, 4'hF);
      do_write(4'h4, 32'hAABBCCDD, 4'b0101);
`ifdef SE_AXIL_WSTRB_EN
      check("strb_merge", reg1, 32'h11BB33DD);
`else
      check("strb_merge", reg1, 32'hAABBCCDD);
`endif
      do_write(4'h4, 32'hFFFFFFFF, 4'h0);
`ifdef SE_AXIL_WSTRB_EN
      check("strb_zero", reg1, 32'h11BB33DD);
`else
      check("strb_zero", reg1, 32'hFFFFFFFF);
`endif
      // Unaligned addresses hit the enclosing word
      do_write(4'h9, 32'h12345678, 4'hF);
      do_read(4'hB, "unaligned");
      check_regs("pre_reset");

      // Reset with both B and R pending
      awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 4'h4; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      tick();
      check("pend_valids", 32'({bvalid, rvalid}), 32'b11);
      #2 aresetn = 1'b0;
      #1;
      exp_q.delete();
      for (int i = 0; i < 4; i++) model[i] = '0;
      check_all_zero("async_rst");
      repeat (2) tick();
      check_all_zero("held_rst");
      @(negedge clk) aresetn = 1'b1;
      #1;
      check("post_rst_no_accept", 32'({awready, wready, arready}), 32'd0);
      tick();
      do_read(4'h0, "post_rst");
      check_regs("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
